// File: rtl/tk_pkg.sv
// Shared widths, limits, FSM encoding and calendar helper for the time_keeper block.
package tk_pkg;
  localparam int HH_W   = 5;
  localparam int MM_W   = 6;
  localparam int SS_W   = 6;
  localparam int PS_W   = 16;
  localparam int HH_MAX = 23;
  localparam int MS_MAX = 59;

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_LOAD} tk_state_e;

  // Leap rule is year%4==0, which is exact for 2000..2099.
  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
    case (m)
      4'd2:                      return (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction
endpackage

// File: rtl/time_keeper_if.sv
// Load handshake and time outputs of time_keeper; calendar fields exist only with TIME_KEEPER_CALENDAR_EN.
interface time_keeper_if;
  import tk_pkg::*;
  logic            run;
  logic            set_valid;
  logic            set_ready;
  logic [HH_W-1:0] set_hh;
  logic [MM_W-1:0] set_mm;
  logic [SS_W-1:0] set_ss;
  logic [HH_W-1:0] hh;
  logic [MM_W-1:0] mm;
  logic [SS_W-1:0] ss;
  logic            tick_1hz;
  logic            day_roll;
  logic            set_err;
`ifdef TIME_KEEPER_CALENDAR_EN
  logic [4:0] set_day, day;
  logic [3:0] set_month, month;
  logic [6:0] set_year, year;

  modport master (output run, set_valid, set_hh, set_mm, set_ss, set_day, set_month, set_year,
                  input  set_ready, hh, mm, ss, tick_1hz, day_roll, set_err, day, month, year);
  modport slave  (input  run, set_valid, set_hh, set_mm, set_ss, set_day, set_month, set_year,
                  output set_ready, hh, mm, ss, tick_1hz, day_roll, set_err, day, month, year);
`else
  modport master (output run, set_valid, set_hh, set_mm, set_ss,
                  input  set_ready, hh, mm, ss, tick_1hz, day_roll, set_err);
  modport slave  (input  run, set_valid, set_hh, set_mm, set_ss,
                  output set_ready, hh, mm, ss, tick_1hz, day_roll, set_err);
`endif
endinterface

// File: rtl/tk_prescaler.sv
// Sub-second counter 0..TICKS-1; tc_o is the combinational terminal-count pulse.
module tk_prescaler
  import tk_pkg::*;
#(
  parameter int TICKS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);
  logic [PS_W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == PS_W'(TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (tc_o)  cnt_d = '0;
    else if (en_i)  cnt_d = cnt_q + PS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/time_keeper.sv
// Hours/minutes/seconds clock with start/stop gate and validated load handshake.
// Optional date calendar when TIME_KEEPER_CALENDAR_EN is defined.
module time_keeper
  import tk_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000
) (
  input logic          clk,
  input logic          rst_n,
  time_keeper_if.slave bus
);
  tk_state_e       state_q, state_d;
  logic            ready_q;
  logic [HH_W-1:0] hh_q, hh_d;
  logic [MM_W-1:0] mm_q, mm_d;
  logic [SS_W-1:0] ss_q, ss_d;
  logic            tick_q, roll_q, err_q;
  logic            acc, set_ok, ps_en, tc, ss_wrap, mm_wrap, hh_wrap, roll;

  assign acc     = bus.set_valid && ready_q;
  // The gate follows the registered state, so a run drop still completes the current edge.
  assign ps_en   = (state_q == ST_RUN) && !acc;
  assign ss_wrap = (ss_q == SS_W'(MS_MAX));
  assign mm_wrap = (mm_q == MM_W'(MS_MAX));
  assign hh_wrap = (hh_q == HH_W'(HH_MAX));
  assign roll    = tc && ss_wrap && mm_wrap && hh_wrap;

  tk_prescaler #(.TICKS(TICKS_PER_SEC)) u_ps (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ps_en),
    .clr_i (acc && set_ok),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: state_d = bus.run ? ST_RUN : ST_STOP;
      ST_RUN:  state_d = bus.run ? ST_RUN : ST_STOP;
      ST_LOAD: state_d = bus.run ? ST_RUN : ST_STOP;
      default: state_d = ST_STOP;
    endcase
    if (acc) state_d = ST_LOAD;
  end

  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (acc) begin
      if (set_ok) begin
        hh_d = bus.set_hh;
        mm_d = bus.set_mm;
        ss_d = bus.set_ss;
      end
    end else if (tc) begin
      ss_d = ss_wrap ? '0 : ss_q + SS_W'(1);
      if (ss_wrap) mm_d = mm_wrap ? '0 : mm_q + MM_W'(1);
      if (ss_wrap && mm_wrap) hh_d = hh_wrap ? '0 : hh_q + HH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_STOP;
      ready_q <= 1'b0;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
      tick_q  <= 1'b0;
      roll_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_LOAD);
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      tick_q  <= tc && !acc;
      roll_q  <= roll && !acc;
      err_q   <= acc && !set_ok;
    end

  assign bus.set_ready = ready_q;
  assign bus.hh        = hh_q;
  assign bus.mm        = mm_q;
  assign bus.ss        = ss_q;
  assign bus.tick_1hz  = tick_q;
  assign bus.day_roll  = roll_q;
  assign bus.set_err   = err_q;

`ifdef TIME_KEEPER_CALENDAR_EN
  logic [4:0] day_q, day_d;
  logic [3:0] mon_q, mon_d;
  logic [6:0] yr_q, yr_d;

  assign set_ok = (bus.set_hh <= HH_W'(HH_MAX)) && (bus.set_mm <= MM_W'(MS_MAX)) &&
                  (bus.set_ss <= SS_W'(MS_MAX)) && (bus.set_month >= 4'd1) &&
                  (bus.set_month <= 4'd12) && (bus.set_day >= 5'd1) &&
                  (bus.set_day <= days_in_month(bus.set_month, bus.set_year)) &&
                  (bus.set_year <= 7'd99);

  always_comb begin
    day_d = day_q;
    mon_d = mon_q;
    yr_d  = yr_q;
    if (acc) begin
      if (set_ok) begin
        day_d = bus.set_day;
        mon_d = bus.set_month;
        yr_d  = bus.set_year;
      end
    end else if (roll) begin
      if (day_q == days_in_month(mon_q, yr_q)) begin
        day_d = 5'd1;
        if (mon_q == 4'd12) begin
          mon_d = 4'd1;
          yr_d  = (yr_q == 7'd99) ? 7'd0 : yr_q + 7'd1;
        end else begin
          mon_d = mon_q + 4'd1;
        end
      end else begin
        day_d = day_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      day_q <= 5'd1;
      mon_q <= 4'd1;
      yr_q  <= 7'd0;
    end else begin
      day_q <= day_d;
      mon_q <= mon_d;
      yr_q  <= yr_d;
    end

  assign bus.day   = day_q;
  assign bus.month = mon_q;
  assign bus.year  = yr_q;
`else
  assign set_ok = (bus.set_hh <= HH_W'(HH_MAX)) && (bus.set_mm <= MM_W'(MS_MAX)) &&
                  (bus.set_ss <= SS_W'(MS_MAX));
`endif
endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper (TICKS_PER_SEC=4) against a seconds-of-day reference model.
module tb_time_keeper;
  localparam int TPS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  time_keeper_if bus ();
  time_keeper #(.TICKS_PER_SEC(TPS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int total = 0;
  int bad = 0;

  // Reference model: time of day as seconds since midnight, sub-second count, run gate, ready.
  int m_tod, m_ps;
  bit m_gate, m_ready;
  bit e_tick, e_roll, e_err;

  typedef struct {
    int hh, mm, ss;
    bit err;
    int ehh, emm, ess;
  } load_vec_t;
  load_vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tod = 0; m_ps = 0; m_gate = 0; m_ready = 0;
    e_tick = 0; e_roll = 0; e_err = 0;
  endtask

  // Advance one clock edge with the inputs currently applied, then compare every output.
  task automatic cycle();
    bit acc, ok, en, tc;
    acc = bus.set_valid && m_ready;
    ok  = (bus.set_hh <= 23) && (bus.set_mm <= 59) && (bus.set_ss <= 59);
    en  = m_gate && !acc;
    tc  = en && (m_ps == TPS - 1);
    e_tick = tc;
    e_roll = tc && (m_tod == 86399);
    e_err  = acc && !ok;
    if (acc && ok) begin
      m_tod = int'(bus.set_hh) * 3600 + int'(bus.set_mm) * 60 + int'(bus.set_ss);
      m_ps  = 0;
    end else begin
      if (tc) m_tod = (m_tod + 1) % 86400;
      if (en) m_ps = (m_ps + 1) % TPS;
    end
    m_gate  = !acc && bus.run;
    m_ready = !acc;
    @(posedge clk);
    @(negedge clk);
    chk("hh", int'(bus.hh), m_tod / 3600);
    chk("mm", int'(bus.mm), (m_tod / 60) % 60);
    chk("ss", int'(bus.ss), m_tod % 60);
    chk("tick_1hz", int'(bus.tick_1hz), int'(e_tick));
    chk("day_roll", int'(bus.day_roll), int'(e_roll));
    chk("set_err", int'(bus.set_err), int'(e_err));
    chk("set_ready", int'(bus.set_ready), int'(m_ready));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_outs"}, int'({bus.hh, bus.mm, bus.ss, bus.tick_1hz, bus.day_roll, bus.set_err}), 0);
    chk({name, "_ready"}, int'(bus.set_ready), 0);
  endtask

  // Assert reset between edges, check outputs clear without an edge, hold across one edge, release.
  task automatic async_reset(input string name);
    #1 rst_n = 1'b0;
    #1 chk_all_zero(name);
    bus.set_valid = 1'b0;
    @(negedge clk);
    chk_all_zero({name, "_held"});
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_until(input int ps, output bit ok);
    ok = 0;
    bus.run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (m_gate && m_ps == ps) begin ok = 1; break; end
      cycle();
    end
    if (!ok) chk("run_until_timeout", m_ps, ps);
  endtask

  task automatic load(input int h, input int m, input int s);
    bus.set_valid = 1'b1;
    bus.set_hh = 5'(h); bus.set_mm = 6'(m); bus.set_ss = 6'(s);
  endtask

  initial begin
    bit ok;
    int rolls, ticks_at_roll;
    vecs[0] = '{12, 34, 56, 0, 12, 34, 56};
    vecs[1] = '{24,  0,  0, 1, 12, 34, 56};
    vecs[2] = '{ 0, 60,  0, 1, 12, 34, 56};
    vecs[3] = '{23, 59, 59, 0, 23, 59, 59};
    vecs[4] = '{ 0,  0, 60, 1, 23, 59, 59};
    vecs[5] = '{ 0,  0,  0, 0,  0,  0,  0};
    vecs[6] = '{31, 63, 63, 1,  0,  0,  0};

    bus.run = 1'b0; bus.set_valid = 1'b0;
    bus.set_hh = '0; bus.set_mm = '0; bus.set_ss = '0;
    model_reset();
    #2 chk_all_zero("reset");
    @(negedge clk);
    chk_all_zero("reset_held");
    rst_n = 1'b1;

    // First edge raises set_ready; run=1 so the gate opens there too.
    bus.run = 1'b1;
    cycle();
    chk("ready_after_release", int'(bus.set_ready), 1);
    for (int i = 1; i <= 8; i++) begin
      cycle();
      chk($sformatf("tick_phase%0d", i), int'(bus.tick_1hz), (i % 4 == 0) ? 1 : 0);
    end
    chk("ss_after_2s", int'(bus.ss), 2);

    // Load table, clock stopped.
    bus.run = 1'b0;
    cycle();
    foreach (vecs[k]) begin
      load(vecs[k].hh, vecs[k].mm, vecs[k].ss);
      cycle();
      chk($sformatf("vec%0d_err", k), int'(bus.set_err), int'(vecs[k].err));
      chk($sformatf("vec%0d_time", k), int'({bus.hh, bus.mm, bus.ss}),
          int'({5'(vecs[k].ehh), 6'(vecs[k].emm), 6'(vecs[k].ess)}));
      chk($sformatf("vec%0d_ready_lo", k), int'(bus.set_ready), 0);
      bus.set_valid = 1'b0;
      cycle();
      chk($sformatf("vec%0d_ready_hi", k), int'(bus.set_ready), 1);
      chk($sformatf("vec%0d_err_clr", k), int'(bus.set_err), 0);
    end

    // Midnight rollover from 23:59:58 while running.
    bus.run = 1'b1;
    load(23, 59, 58);
    cycle();
    bus.set_valid = 1'b0;
    rolls = 0; ticks_at_roll = 0;
    for (int i = 0; i < 11; i++) begin
      cycle();
      if (bus.day_roll) begin rolls++; ticks_at_roll += int'(bus.tick_1hz); end
    end
    chk("midnight_rolls", rolls, 1);
    chk("midnight_roll_with_tick", ticks_at_roll, 1);
    chk("midnight_time", int'({bus.hh, bus.mm, bus.ss}), 0);

    // Stop mid-second at prescaler 2, hold 10 cycles, restart: tick two cycles later.
    run_until(2, ok);
    bus.run = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    bus.run = 1'b1;
    cycle();
    chk("resume_tick_c1", int'(bus.tick_1hz), 0);
    cycle();
    chk("resume_tick_c2", int'(bus.tick_1hz), 1);

    // run dropped on terminal count still increments.
    run_until(TPS - 1, ok);
    bus.run = 1'b0;
    cycle();
    chk("stop_on_tc_tick", int'(bus.tick_1hz), 1);

    // Load accepted on terminal count wins over the tick.
    run_until(TPS - 1, ok);
    load(10, 20, 30);
    cycle();
    bus.set_valid = 1'b0;
    chk("load_on_tc_no_tick", int'(bus.tick_1hz), 0);
    chk("load_on_tc_time", int'({bus.hh, bus.mm, bus.ss}), int'({5'd10, 6'd20, 6'd30}));

    // Reset in LOAD and mid-count.
    load(5, 6, 7);
    cycle();
    async_reset("rst_in_load");
    bus.run = 1'b1;
    cycle();
    cycle();
    cycle();
    async_reset("rst_mid_count");
    bus.run = 1'b1;
    cycle();

    // Randomised traffic with occasional near-midnight loads.
    for (int i = 0; i < 600; i++) begin
      bus.run = ($urandom_range(0, 9) != 0);
      if (!(bus.set_valid && !bus.set_ready)) begin
        bus.set_valid = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 2) == 0) begin
          bus.set_hh = 5'd23; bus.set_mm = 6'd59; bus.set_ss = 6'($urandom_range(55, 59));
        end else begin
          bus.set_hh = 5'($urandom_range(0, 25));
          bus.set_mm = 6'($urandom_range(0, 61));
          bus.set_ss = 6'($urandom_range(0, 61));
        end
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1000, clk cycles per second (1 ms clk period); legal range 2..65535.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 run  in  1  level; 1 = timekeeping advances, 0 = frozen (start/stop gate).
REQ-005 set_valid  in  1  load request; held until accepted.
REQ-006 set_ready  out  1  load may be accepted this cycle.
REQ-007 set_hh / set_mm / set_ss  in  5/6/6  binary load values.
REQ-008 hh / mm / ss  out  5/6/6  binary current time.
REQ-009 tick_1hz  out  1  one-cycle pulse on each seconds increment.
REQ-010 day_roll  out  1  one-cycle pulse on 23:59:59 -> 00:00:00.
REQ-011 set_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-012 Prescaler counts 0..TICKS_PER_SEC-1 only while state RUN; at TICKS_PER_SEC-1 it wraps to 0 and seconds increment in that cycle.
REQ-013 Registered outputs; hh/mm/ss and tick_1hz update on the same edge; latency from prescaler terminal count to new ss = 1 cycle.
REQ-014 Cascade: ss 59->0 carries mm; mm 59->0 carries hh; hh 23->0 asserts day_roll with the rollover edge.
REQ-015 States: STOP (run=0), RUN (run=1), LOAD (one cycle). STOP->RUN when run=1; RUN->STOP when run=0 (prescaler holds its value, no partial-second loss); any state->LOAD on set_valid&set_ready; LOAD->RUN or STOP per run.
REQ-016 set_ready = 1 in STOP and RUN, 0 in LOAD; handshake completes on a cycle with set_valid=1 and set_ready=1.
REQ-017 Accepted load with set_hh<=23, set_mm<=59, set_ss<=59: time takes the set values on the LOAD edge and the prescaler clears to 0.
REQ-018 Out-of-range load: time unchanged, prescaler unchanged, set_err pulses for 1 cycle, LOAD still taken (handshake consumed).
REQ-019 Load accepted in the same cycle as a terminal count: load wins; no tick_1hz, no day_roll that cycle.
REQ-020 run deasserted on a terminal-count cycle: the increment still occurs in that cycle.

Reset
REQ-021 Asynchronous on rst_n low: state STOP, prescaler 0, hh=mm=ss=0, tick_1hz=day_roll=set_err=0, set_ready=0 while rst_n low.
REQ-022 After rst_n release, set_ready rises on the first clk edge; reset mid-LOAD discards the load.

Configuration
REQ-023 Macro TIME_KEEPER_CALENDAR_EN defined: extra outputs day (5, 1..31), month (4, 1..12), year (7, 0..99 = 2000..2099) and inputs set_day/set_month/set_year; day_roll advances the date with month lengths and leap year (year%4==0); 31 Dec 99 wraps to 01 Jan 00; reset date 01-01-00; a load checks date validity per REQ-018.
REQ-024 Macro undefined: calendar ports and logic are absent; all other behaviour identical.

Structure
REQ-025 Shared package tk_pkg holds field widths, limits (23, 59), state encoding, and the days-in-month function.
REQ-026 One sub-module tk_prescaler (counter, enable, clear, terminal-count pulse); the cascade and FSM stay in time_keeper.

Verification
REQ-027 Reset, run=1, TICKS_PER_SEC=4: ss=1 after 4 cycles, tick_1hz each 4th cycle, exactly 1 cycle wide.
REQ-028 Load 23:59:58 with run=1: after 2 seconds hh=mm=ss=0, day_roll pulses once, coincident with tick_1hz.
REQ-029 Load 24:00:00: set_err pulses, time unchanged, set_ready low exactly 1 cycle.
REQ-030 run dropped mid-second at prescaler=2, held 10 cycles, re-raised: next tick after 2 more cycles.
REQ-031 rst_n low during LOAD and mid-count: all outputs 0 immediately, without waiting for a clk edge.
REQ-032 With TIME_KEEPER_CALENDAR_EN: 28-02-24 23:59:59 -> 29-02-24; 28-02-23 -> 01-03-23; 31-12-99 -> 01-01-00.
